// File: rtl/apb_pkg.sv
// Shared widths and FSM state type for the APB initiator bridge.
// Data is 8 bits and the slave id is 2 bits across the whole APB segment.
package apb_pkg;

  localparam int APB_DATA_W = 8;
  localparam int APB_SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    ERR    = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting for pready and flags the last allowed one.
// Saturates at TIMEOUT_CYC, and clear has priority over enable.
module apb_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expires on the cycle whose increment would make the count reach TIMEOUT_CYC.
  assign expired = enable && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 initiator: valid/ready request in, registered SETUP/ACCESS out, one-cycle response strobe.
// Accept-to-response is 3 cycles plus wait states; req_ready is high in IDLE and in a completing ACCESS.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_SLAVES  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_SEL_W-1:0]  req_sel,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [APB_DATA_W-1:0] pwdata,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pready
);

  apb_state_t state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]     paddr_q, paddr_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  err_pend_q, err_pend_d;

  logic                  take_req;
  logic                  sel_ok;
  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  tmr_clear;
  logic                  tmr_enable;
  logic                  tmr_expired;

  assign req_ready = (state_q == IDLE) || ((state_q == ACCESS) && pready);
  assign sel_ok    = (int'(req_sel) < NUM_SLAVES);

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_onehot[i] = (int'(req_sel) == i);
    end
  end

  assign tmr_enable = (state_q == ACCESS) && !pready;
  assign tmr_clear  = (state_q != ACCESS) || pready || tmr_expired;

  apb_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    err_pend_d  = 1'b0;
    take_req    = 1'b0;

    case (state_q)
      IDLE: begin
        take_req = req_valid;
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
          take_req    = req_valid;
        end else if (tmr_expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      ERR: begin
        // A deferred error strobe goes out one cycle late so it never collides with a completion.
        rsp_valid_d = err_pend_q;
        rsp_err_d   = err_pend_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_req) begin
      pwrite_d  = req_write;
      paddr_d   = req_addr;
      pwdata_d  = req_wdata;
      penable_d = 1'b0;
      if (sel_ok) begin
        psel_d  = sel_onehot;
        state_d = SETUP;
      end else begin
        psel_d  = '0;
        state_d = ERR;
        if (state_q == ACCESS) begin
          err_pend_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_pend_q  <= err_pend_d;
    end
  end

  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slave memory plus an array-based expected memory.
// A second instance with three slaves covers out-of-range select handling.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_sel;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic [3:0] psel;
  logic       penable, pwrite, pready;
  logic [7:0] paddr, pwdata, prdata;

  logic       r3_valid, r3_ready, r3_write;
  logic [1:0] r3_sel;
  logic [7:0] r3_addr, r3_wdata;
  logic       s3_valid, s3_err;
  logic [7:0] s3_rdata;
  logic [2:0] psel3;
  logic       penable3, pwrite3;
  logic [7:0] paddr3, pwdata3;
  logic [7:0] prdata3;
  logic       pready3;

  int n_checks = 0;
  int n_fail   = 0;

  apb_master_bridge #(.ADDR_W(8), .NUM_SLAVES(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_sel(req_sel), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_master_bridge #(.ADDR_W(8), .NUM_SLAVES(3), .TIMEOUT_CYC(TMO)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
    .req_sel(r3_sel), .req_addr(r3_addr), .req_wdata(r3_wdata),
    .rsp_valid(s3_valid), .rsp_rdata(s3_rdata), .rsp_err(s3_err),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .prdata(prdata3), .pready(pready3)
  );

  // Slave for the three-slave instance is always ready, so pready must be ignored outside ACCESS.
  assign pready3 = 1'b1;
  assign prdata3 = 8'h77;

  // Behavioural slave: ready after slave_wait ACCESS cycles (negative = never).
  int slave_wait = 0;
  int acc_cnt    = 0;
  byte unsigned slave_mem [4][256];
  byte unsigned ref_mem   [4][256];
  logic [1:0] psel_idx;

  always_comb begin
    psel_idx = 2'd0;
    for (int i = 0; i < 4; i++) if (psel[i]) psel_idx = 2'(i);
  end

  assign pready = (psel != 4'd0) && penable && (slave_wait >= 0) && (acc_cnt == slave_wait);
  assign prdata = pready ? slave_mem[psel_idx][paddr] : 8'h5A;

  always @(posedge clk) begin
    if ((psel != 4'd0) && penable) begin
      if (pready) begin
        acc_cnt <= 0;
        if (pwrite) slave_mem[psel_idx][paddr] <= pwdata;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // Runs one transaction on the main instance; entered and left at a falling edge.
  task automatic run_txn(input logic wr, input logic [1:0] sel, input logic [7:0] addr,
                         input logic [7:0] wd, input int wt,
                         output int lat, output logic err, output logic [7:0] rd,
                         output int en_cyc, output logic [3:0] psel_seen,
                         output logic stable, output logic [3:0] psel_at_rsp);
    int guard;
    slave_wait = wt;
    req_valid = 1'b1; req_write = wr; req_sel = sel; req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 40) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; en_cyc = 0; psel_seen = 4'd0; stable = 1'b1;
    while (!rsp_valid && lat < 60) begin
      if (penable) en_cyc++;
      psel_seen = psel_seen | psel;
      if ((psel != 4'd0) && ((paddr !== addr) || (pwrite !== wr) || (wr && (pwdata !== wd))))
        stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    err = rsp_err; rd = rsp_rdata; psel_at_rsp = psel;
  endtask

  task automatic test_reset();
    n_checks++; if (psel !== 4'd0) begin n_fail++; $display("FAIL reset_psel: got %b expected 0000", psel); end
    n_checks++; if (penable !== 1'b0) begin n_fail++; $display("FAIL reset_penable: got %b expected 0", penable); end
    n_checks++; if (pwrite !== 1'b0) begin n_fail++; $display("FAIL reset_pwrite: got %b expected 0", pwrite); end
    n_checks++; if (paddr !== 8'd0) begin n_fail++; $display("FAIL reset_paddr: got %h expected 00", paddr); end
    n_checks++; if (pwdata !== 8'd0) begin n_fail++; $display("FAIL reset_pwdata: got %h expected 00", pwdata); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 8'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 00", rsp_rdata); end
    n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", rsp_err); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    n_checks++; if (r3_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready3: got %b expected 1", r3_ready); end
  endtask

  task automatic test_write_read();
    int lat, en; logic err, st; logic [7:0] rd; logic [3:0] ps, pr;
    run_txn(1'b1, 2'd1, 8'h10, 8'hA5, 0, lat, err, rd, en, ps, st, pr);
    ref_mem[1][8'h10] = 8'hA5;
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b expected 0", err); end
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL wr_rdata: got %h expected 00", rd); end
    n_checks++; if (ps !== 4'b0010) begin n_fail++; $display("FAIL wr_psel: got %b expected 0010", ps); end
    n_checks++; if (en !== 1) begin n_fail++; $display("FAIL wr_penable_cycles: got %0d expected 1", en); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL wr_stable: got %b expected 1", st); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_single_pulse: got %b expected 0", rsp_valid); end
    run_txn(1'b0, 2'd1, 8'h10, 8'h00, 0, lat, err, rd, en, ps, st, pr);
    n_checks++; if (rd !== ref_mem[1][8'h10]) begin n_fail++; $display("FAIL rd_data: got %h expected %h", rd, ref_mem[1][8'h10]); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL rd_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_wait_states();
    int lat, en; logic err, st; logic [7:0] rd; logic [3:0] ps, pr;
    run_txn(1'b1, 2'd2, 8'h44, 8'h6B, 1, lat, err, rd, en, ps, st, pr);
    ref_mem[2][8'h44] = 8'h6B;
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL ws1_latency: got %0d expected 4", lat); end
    run_txn(1'b0, 2'd2, 8'h44, 8'h00, 3, lat, err, rd, en, ps, st, pr);
    n_checks++; if (en !== 4) begin n_fail++; $display("FAIL ws3_penable_cycles: got %0d expected 4", en); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL ws3_addr_stable: got %b expected 1", st); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL ws3_latency: got %0d expected 6", lat); end
    n_checks++; if (rd !== ref_mem[2][8'h44]) begin n_fail++; $display("FAIL ws3_rdata: got %h expected %h", rd, ref_mem[2][8'h44]); end
    n_checks++; if (ps !== 4'b0100) begin n_fail++; $display("FAIL ws3_psel: got %b expected 0100", ps); end
  endtask

  task automatic test_timeout();
    int lat, en; logic err, st; logic [7:0] rd; logic [3:0] ps, pr;
    run_txn(1'b0, 2'd0, 8'h10, 8'h00, -1, lat, err, rd, en, ps, st, pr);
    n_checks++; if (lat !== TMO + 2) begin n_fail++; $display("FAIL tmo_latency: got %0d expected %0d", lat, TMO + 2); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", err); end
    n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL tmo_rdata: got %h expected 00", rd); end
    n_checks++; if (en !== TMO) begin n_fail++; $display("FAIL tmo_penable_cycles: got %0d expected %0d", en, TMO); end
    n_checks++; if (pr !== 4'd0) begin n_fail++; $display("FAIL tmo_psel_after: got %b expected 0000", pr); end
    // Last wait count that still completes, then the first one that aborts.
    run_txn(1'b1, 2'd3, 8'h05, 8'h99, TMO - 1, lat, err, rd, en, ps, st, pr);
    ref_mem[3][8'h05] = 8'h99;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL edge_ok_err: got %b expected 0", err); end
    n_checks++; if (lat !== TMO + 2) begin n_fail++; $display("FAIL edge_ok_latency: got %0d expected %0d", lat, TMO + 2); end
    run_txn(1'b1, 2'd3, 8'h05, 8'h11, TMO, lat, err, rd, en, ps, st, pr);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL edge_abort_err: got %b expected 1", err); end
    run_txn(1'b0, 2'd3, 8'h05, 8'h00, 0, lat, err, rd, en, ps, st, pr);
    n_checks++; if (rd !== ref_mem[3][8'h05]) begin n_fail++; $display("FAIL edge_readback: got %h expected %h", rd, ref_mem[3][8'h05]); end
  endtask

  task automatic test_invalid_sel();
    logic [2:0] exp_psel [5] = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b000};
    logic       exp_pen  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_vld  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic       exp_err  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit drop;
    r3_valid = 1'b1; r3_write = 1'b0; r3_sel = 2'd3; r3_addr = 8'h12; r3_wdata = 8'h00;
    n_checks++; if (r3_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready_idle: got %b expected 1", r3_ready); end
    @(negedge clk);
    r3_valid = 1'b0;
    n_checks++; if (s3_valid !== 1'b1) begin n_fail++; $display("FAIL inv_rsp_valid: got %b expected 1", s3_valid); end
    n_checks++; if (s3_err !== 1'b1) begin n_fail++; $display("FAIL inv_rsp_err: got %b expected 1", s3_err); end
    n_checks++; if (s3_rdata !== 8'h00) begin n_fail++; $display("FAIL inv_rsp_rdata: got %h expected 00", s3_rdata); end
    n_checks++; if ({psel3, penable3} !== 4'd0) begin n_fail++; $display("FAIL inv_no_psel: got %b expected 0000", {psel3, penable3}); end
    @(negedge clk);
    n_checks++; if (s3_valid !== 1'b0) begin n_fail++; $display("FAIL inv_single_pulse: got %b expected 0", s3_valid); end
    n_checks++; if (r3_ready !== 1'b1) begin n_fail++; $display("FAIL inv_ready_after: got %b expected 1", r3_ready); end
    // Valid write to slave 0 immediately followed by an out-of-range select.
    r3_valid = 1'b1; r3_write = 1'b1; r3_sel = 2'd0; r3_addr = 8'h01; r3_wdata = 8'h0F;
    @(negedge clk);
    r3_sel = 2'd3;
    drop = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({psel3, penable3, s3_valid, s3_err} !== {exp_psel[k], exp_pen[k], exp_vld[k], exp_err[k]}) begin
        n_fail++;
        $display("FAIL inv_b2b[%0d]: got psel=%b en=%b vld=%b err=%b expected psel=%b en=%b vld=%b err=%b",
                 k, psel3, penable3, s3_valid, s3_err, exp_psel[k], exp_pen[k], exp_vld[k], exp_err[k]);
      end
      if (drop) r3_valid = 1'b0;
      else if (r3_ready) drop = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_psel [6] = '{4'b0001, 4'b0001, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    logic       exp_pen  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_vld  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat, en; logic err, st; logic [7:0] rd; logic [3:0] ps, pr;
    int pulses;
    bit drop;
    slave_wait = 0;
    req_valid = 1'b1; req_write = 1'b1; req_sel = 2'd0; req_addr = 8'h20; req_wdata = 8'h3C;
    @(negedge clk);
    req_sel = 2'd3; req_addr = 8'h21; req_wdata = 8'hC3;
    ref_mem[0][8'h20] = 8'h3C;
    ref_mem[3][8'h21] = 8'hC3;
    drop = 1'b0; pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (rsp_valid) pulses++;
      n_checks++;
      if ({psel, penable, rsp_valid, rsp_err} !== {exp_psel[k], exp_pen[k], exp_vld[k], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got psel=%b en=%b vld=%b err=%b expected psel=%b en=%b vld=%b err=0",
                 k, psel, penable, rsp_valid, rsp_err, exp_psel[k], exp_pen[k], exp_vld[k]);
      end
      if (drop) req_valid = 1'b0;
      else if (req_ready) drop = 1'b1;
      @(negedge clk);
    end
    n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 2", pulses); end
    run_txn(1'b0, 2'd3, 8'h21, 8'h00, 0, lat, err, rd, en, ps, st, pr);
    n_checks++; if (rd !== ref_mem[3][8'h21]) begin n_fail++; $display("FAIL b2b_readback: got %h expected %h", rd, ref_mem[3][8'h21]); end
  endtask

  task automatic test_random();
    int lat, en; logic err, st; logic [7:0] rd; logic [3:0] ps, pr;
    for (int t = 0; t < 30; t++) begin
      logic wr; logic [1:0] sel; logic [7:0] addr, wd, exp_rd;
      int wt, r, exp_lat, exp_en; bit tmo;
      wr   = 1'($urandom_range(0, 1));
      sel  = 2'($urandom_range(0, 3));
      addr = 8'($urandom_range(0, 7));
      wd   = 8'($urandom);
      r    = int'($urandom_range(0, 9));
      wt   = (r <= 6) ? r : (r == 7) ? TMO - 1 : (r == 8) ? TMO : -1;
      tmo     = (wt < 0) || (wt >= TMO);
      exp_lat = tmo ? TMO + 2 : wt + 3;
      exp_en  = tmo ? TMO : wt + 1;
      exp_rd  = (tmo || wr) ? 8'h00 : ref_mem[sel][addr];
      if (!tmo && wr) ref_mem[sel][addr] = wd;
      run_txn(wr, sel, addr, wd, wt, lat, err, rd, en, ps, st, pr);
      n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand[%0d] latency: got %0d expected %0d", t, lat, exp_lat); end
      n_checks++; if (err !== tmo) begin n_fail++; $display("FAIL rand[%0d] err: got %b expected %b", t, err, tmo); end
      n_checks++; if (rd !== exp_rd) begin n_fail++; $display("FAIL rand[%0d] rdata: got %h expected %h", t, rd, exp_rd); end
      n_checks++; if (en !== exp_en) begin n_fail++; $display("FAIL rand[%0d] penable_cycles: got %0d expected %0d", t, en, exp_en); end
      n_checks++; if (ps !== (4'd1 << sel)) begin n_fail++; $display("FAIL rand[%0d] psel: got %b expected %b", t, ps, 4'd1 << sel); end
      n_checks++; if ({st, pr} !== 5'b10000) begin n_fail++; $display("FAIL rand[%0d] stable/psel_end: got %b/%b expected 1/0000", t, st, pr); end
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    slave_wait = -1;
    req_valid = 1'b1; req_write = 1'b0; req_sel = 2'd2; req_addr = 8'h33; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if ({psel, penable} !== 5'b01001) begin n_fail++; $display("FAIL rst_mid_in_access: got %b expected 01001", {psel, penable}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({psel, penable, rsp_valid} !== 6'd0) begin n_fail++; $display("FAIL rst_mid_async: got %b expected 000000", {psel, penable, rsp_valid}); end
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || (psel != 4'd0)) stale++;
    end
    n_checks++; if (stale !== 0) begin n_fail++; $display("FAIL rst_mid_stale: got %0d active cycles expected 0", stale); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_sel = 2'd0; req_addr = 8'd0; req_wdata = 8'd0;
    r3_valid = 1'b0; r3_write = 1'b0; r3_sel = 2'd0; r3_addr = 8'd0; r3_wdata = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_wait_states();
    test_timeout();
    test_invalid_sel();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
